i2s_rx_176: RTL
===============

# i2s_rx_176

I2S receiver that deserializes the 176.4 kHz stereo stream into signed 32-bit parallel words. It feeds `down_882` (`x0`/`x1`) and runs in the same `bck176` domain: 64 `bck` per frame, 32 bits per channel, MSB first. It checks frame alignment and reports lock. Samples are forwarded only while locked; on loss of lock the outputs are muted to zero.

## Interface
- `WIDTH`, 32, bits per channel slot
- `LOCK_FRAMES`, 4, consecutive good frames required before `locked` asserts
- `bck176` in 1: 176.4 kHz × 64 bit clock; all logic on the rising edge
- `reset_n` in 1: reset, asynchronous, active-low
- `lrck` in 1: word clock; 0 = left, 1 = right; changes one `bck` before the MSB (I2S delay)
- `sdata` in 1: serial data
- `x0` out 32: signed left sample, to `down_882.x0`
- `x1` out 32: signed right sample, to `down_882.x1`
- `frame_strobe` out 1: one-cycle pulse when `x0`/`x1` update
- `locked` out 1: frame alignment established
- `slip_err` out 1: one-cycle pulse on loss of lock

## Operation
- **Sampling:** `lrck` and `sdata` are sampled every rising edge. `lrck_d` is the previous sample.
  - fall = `lrck_d & ~lrck`
  - rise = `~lrck_d & lrck`
- **Shift register:** 63-bit history `sr` shifts `sdata` in every cycle. At a fall cycle, the word `{sr, sdata}` holds left in bits [63:32] and right in bits [31:0]. At that cycle `sdata` is the right LSB.
- **Bit counter:** 7-bit `cnt`.
  - Cleared to 0 on fall.
  - Otherwise increments, saturating at 127.
- **Frame flags:**
  - Rise with `cnt==31` sets `mid_ok`.
  - Rise at any other count sets `bad`.
  - Both flags clear on fall.
- **Good frame:** fall with `cnt==63 && mid_ok && !bad`. Any other fall is a bad frame.
- **States** (`good_cnt` is 3 bits):
  - **HUNT:** on fall go to CHECK, `good_cnt=0`.
  - **CHECK:**
    - Good frame: `good_cnt++`. When it reaches `LOCK_FRAMES`, go to LOCKED and capture this frame.
    - Bad frame: `good_cnt=0`; stay in CHECK, since this fall is the new frame origin.
    - `cnt==127`: go to HUNT.
  - **LOCKED:**
    - Good frame: capture.
    - Bad frame: go to CHECK, `good_cnt=0`, `slip_err` pulse, `x0`/`x1` ← 0.
    - `cnt==127`: go to HUNT, `slip_err` pulse, `x0`/`x1` ← 0.
- **Capture:** `x0` ← word[63:32], `x1` ← word[31:0], `frame_strobe` ← 1. No rescaling or sign extension.
- `locked` = (state == LOCKED).
- `x0`/`x1` hold their value between captures, so they are stable for 64 cycles. This satisfies `down_882`, which latches at its `i[5:0]==2`.
- In HUNT/CHECK the outputs stay at 0 and no `frame_strobe` is issued.

## Timing
- **Reset values:**
  - `x0`, `x1`, `frame_strobe`, `slip_err`, `cnt`, `sr`, `good_cnt` = 0
  - `lrck_d` = 0, so no false fall occurs after reset
  - state = HUNT, `locked` = 0
- **Latency:** the right LSB sampled at edge k appears on `x1` after edge k. `frame_strobe` is high for exactly the cycle after edge k.
- `locked` rises after the edge of the `LOCK_FRAMES`-th good fall, i.e. the 5th fall from HUNT. The first strobe comes at the same edge.
- **Simultaneous events:**
  - fall and `cnt==127` in the same cycle: the fall is processed (bad frame) and the timeout is ignored.
  - rise and fall cannot coincide.
- **Reset mid-frame:** all state is cleared immediately and the partial frame is discarded.
- `slip_err` and `frame_strobe` are never high in the same cycle.

## Structure
- Package `down_pkg`:
  - state enum `RX_HUNT` / `RX_CHECK` / `RX_LOCKED`
  - `FRAME_BCK=64`, `HALF_BCK=32`, `CNT_TIMEOUT=127`
- Sub-module `i2s_frame_chk`: edge detect, `cnt`, `mid_ok`/`bad`, and the good/bad/timeout decode.
- The top level holds the FSM, `sr`, and the output registers.

## Test plan
- Clean I2S, left=`0x12345678`, right=`0x87654321` every frame → `locked` after 5th fall; `x0=0x12345678`, `x1=0x87654321`; one strobe per 64 cycles.
- Negative full scale, left=`0x80000000`, right=`0xFFFFFFFF` → outputs bit-exact; passed into `down_882` the result is a stable nonzero 88.2 kHz output.
- While locked, insert one 63-`bck` frame → `slip_err` single pulse, `x0=x1=0`, `locked=0`; relock after 4 further good frames.
- `lrck` stuck low for 200 cycles while locked → at `cnt==127`: HUNT, `slip_err` pulse, outputs 0, no strobe.
- Rise at `cnt==30` (early right slot) → frame bad, `good_cnt` resets, no capture.
- Assert `reset_n` low mid-frame at bit 17 → all outputs 0 asynchronously; after release a full relock sequence is needed (5 falls).

Source files
------------

// File: rtl/i2s_rx_176_pkg.sv
// -----------------------------------------------------------------------------
// down_pkg
// Shared definitions for the 176.4 kHz I2S receiver slice:
//   - rx_state_e     : alignment FSM states (hunt / check / locked)
//   - FRAME_BCK      : bit clocks per stereo frame
//   - HALF_BCK       : bit clocks per channel slot
//   - CNT_TIMEOUT    : saturating bit-count value that signals a lost word clock
//   - cnt_sat_inc()  : saturating increment for the 7-bit bit counter
// -----------------------------------------------------------------------------
package down_pkg;

   typedef enum logic [1:0] {
      RX_HUNT   = 2'd0,
      RX_CHECK  = 2'd1,
      RX_LOCKED = 2'd2
   } rx_state_e;

   localparam int FRAME_BCK   = 64;
   localparam int HALF_BCK    = 32;
   localparam int CNT_TIMEOUT = 127;
   localparam int CNT_W       = 7;

   // Bit counter increment that sticks at the timeout value.
   function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
      logic [CNT_W-1:0] r;
      if (c == CNT_W'(CNT_TIMEOUT)) begin
         r = c;
      end else begin
         r = c + 7'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/i2s_rx_176_if.sv
// -----------------------------------------------------------------------------
// i2s_rx_176_if
// Bundles the serial I2S inputs and the parallel sample outputs of i2s_rx_176.
//   lrck, sdata         : serial word clock and data (source -> receiver)
//   x0, x1              : signed left / right samples (receiver -> consumer)
//   frame_strobe        : one-cycle pulse when x0/x1 update
//   locked              : frame alignment established
//   slip_err            : one-cycle pulse on loss of lock
// Modports: master = stream source / sample consumer, slave = receiver.
// -----------------------------------------------------------------------------
interface i2s_rx_176_if #(
   parameter int WIDTH = 32
);
   logic             lrck;
   logic             sdata;
   logic [WIDTH-1:0] x0;
   logic [WIDTH-1:0] x1;
   logic             frame_strobe;
   logic             locked;
   logic             slip_err;

   modport master (
      output lrck, sdata,
      input  x0, x1, frame_strobe, locked, slip_err
   );

   modport slave (
      input  lrck, sdata,
      output x0, x1, frame_strobe, locked, slip_err
   );
endinterface

// File: rtl/i2s_rx_176_frame_chk.sv
// -----------------------------------------------------------------------------
// i2s_frame_chk
// Word-clock alignment checker for the I2S receiver.
//   bck176     in  : bit clock, rising edge
//   reset_n    in  : asynchronous active-low reset
//   lrck       in  : word clock (0 = left, 1 = right)
//   fall       out : lrck falling edge seen this cycle (frame boundary)
//   good_frame out : fall closing a 64-bit frame with its rise at mid-frame
//   bad_frame  out : any other fall
//   timeout    out : bit counter saturated with no fall this cycle
// The decode outputs are combinational so the FSM in the top level acts on
// them at the very edge that samples the fall.
// -----------------------------------------------------------------------------
module i2s_frame_chk
   import down_pkg::*;
(
   input  logic bck176,
   input  logic reset_n,
   input  logic lrck,
   output logic fall,
   output logic good_frame,
   output logic bad_frame,
   output logic timeout
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BCK - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_BCK - 1);
   localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(CNT_TIMEOUT);

   logic             lrck_d_q, lrck_d_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mid_ok_q, mid_ok_d;
   logic             bad_q, bad_d;
   logic             rise_s;

   assign fall       = lrck_d_q & ~lrck;
   assign rise_s     = ~lrck_d_q & lrck;
   // Flags are evaluated before the fall clears them.
   assign good_frame = fall & (cnt_q == CNT_LAST) & mid_ok_q & ~bad_q;
   assign bad_frame  = fall & ~good_frame;
   // A fall at the saturated count is treated as a frame boundary, not a timeout.
   assign timeout    = (cnt_q == CNT_TO) & ~fall;

   // Next-state for bit counter and slot flags.
   always_comb begin
      lrck_d_d = lrck;
      cnt_d    = cnt_q;
      mid_ok_d = mid_ok_q;
      bad_d    = bad_q;
      if (fall) begin
         cnt_d    = {CNT_W{1'b0}};
         mid_ok_d = 1'b0;
         bad_d    = 1'b0;
      end else begin
         cnt_d = cnt_sat_inc(cnt_q);
         if (rise_s) begin
            if (cnt_q == CNT_MID) begin
               mid_ok_d = 1'b1;
            end else begin
               bad_d = 1'b1;
            end
         end else begin
            mid_ok_d = mid_ok_q;
            bad_d    = bad_q;
         end
      end
   end

   // Checker state registers; lrck_d resets low so no false fall follows reset.
   always_ff @(posedge bck176 or negedge reset_n) begin
      if (!reset_n) begin
         lrck_d_q <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
         mid_ok_q <= 1'b0;
         bad_q    <= 1'b0;
      end else begin
         lrck_d_q <= lrck_d_d;
         cnt_q    <= cnt_d;
         mid_ok_q <= mid_ok_d;
         bad_q    <= bad_d;
      end
   end

endmodule

// File: rtl/i2s_rx_176.sv
// -----------------------------------------------------------------------------
// i2s_rx_176
// I2S receiver for the 176.4 kHz stereo stream (64 bck per frame, MSB first).
// Deserializes left/right into signed 32-bit words for down_882, tracks frame
// alignment and only forwards samples while locked; outputs mute to zero on
// loss of lock.
//   bck176   in : bit clock, all logic on rising edge
//   reset_n  in : asynchronous active-low reset
//   bus         : i2s_rx_176_if.slave (lrck, sdata in; x0, x1, frame_strobe,
//                 locked, slip_err out)
// -----------------------------------------------------------------------------
module i2s_rx_176
   import down_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int LOCK_FRAMES = 4
)(
   input  logic         bck176,
   input  logic         reset_n,
   i2s_rx_176_if.slave  bus
);

   localparam int         WORD_W   = 2 * WIDTH;
   localparam logic [2:0] LOCK_CNT = 3'(LOCK_FRAMES);

   logic              fall_s;
   logic              good_frame_s;
   logic              bad_frame_s;
   logic              timeout_s;

   logic [WORD_W-2:0] sr_q, sr_d;
   logic [WORD_W-1:0] word_s;
   rx_state_e         state_q, state_d;
   logic [2:0]        good_cnt_q, good_cnt_d;
   logic [2:0]        good_cnt_inc_s;
   logic [WIDTH-1:0]  x0_q, x0_d;
   logic [WIDTH-1:0]  x1_q, x1_d;
   logic              frame_strobe_q, frame_strobe_d;
   logic              slip_err_q, slip_err_d;
   logic              locked_q, locked_d;

   i2s_frame_chk u_frame_chk (
      .bck176     (bck176),
      .reset_n    (reset_n),
      .lrck       (bus.lrck),
      .fall       (fall_s),
      .good_frame (good_frame_s),
      .bad_frame  (bad_frame_s),
      .timeout    (timeout_s)
   );

   // At a fall the live sdata bit is the right-channel LSB, completing the word.
   assign word_s         = {sr_q, bus.sdata};
   assign good_cnt_inc_s = good_cnt_q + 3'd1;

   // Serial history shift.
   always_comb begin
      sr_d = {sr_q[WORD_W-3:0], bus.sdata};
   end

   // Alignment FSM next-state, capture and mute decode.
   always_comb begin
      state_d        = state_q;
      good_cnt_d     = good_cnt_q;
      x0_d           = x0_q;
      x1_d           = x1_q;
      frame_strobe_d = 1'b0;
      slip_err_d     = 1'b0;
      case (state_q)
         RX_HUNT: begin
            if (fall_s) begin
               state_d    = RX_CHECK;
               good_cnt_d = 3'd0;
            end else begin
               state_d = RX_HUNT;
            end
         end
         RX_CHECK: begin
            if (good_frame_s) begin
               good_cnt_d = good_cnt_inc_s;
               if (good_cnt_inc_s == LOCK_CNT) begin
                  state_d        = RX_LOCKED;
                  x0_d           = word_s[WORD_W-1:WIDTH];
                  x1_d           = word_s[WIDTH-1:0];
                  frame_strobe_d = 1'b1;
               end else begin
                  state_d = RX_CHECK;
               end
            end else if (bad_frame_s) begin
               // This fall becomes the new frame origin.
               good_cnt_d = 3'd0;
               state_d    = RX_CHECK;
            end else if (timeout_s) begin
               state_d = RX_HUNT;
            end else begin
               state_d = RX_CHECK;
            end
         end
         RX_LOCKED: begin
            if (good_frame_s) begin
               x0_d           = word_s[WORD_W-1:WIDTH];
               x1_d           = word_s[WIDTH-1:0];
               frame_strobe_d = 1'b1;
            end else if (bad_frame_s) begin
               state_d    = RX_CHECK;
               good_cnt_d = 3'd0;
               slip_err_d = 1'b1;
               x0_d       = {WIDTH{1'b0}};
               x1_d       = {WIDTH{1'b0}};
            end else if (timeout_s) begin
               state_d    = RX_HUNT;
               slip_err_d = 1'b1;
               x0_d       = {WIDTH{1'b0}};
               x1_d       = {WIDTH{1'b0}};
            end else begin
               state_d = RX_LOCKED;
            end
         end
         default: begin
            state_d    = RX_HUNT;
            good_cnt_d = 3'd0;
            x0_d       = {WIDTH{1'b0}};
            x1_d       = {WIDTH{1'b0}};
         end
      endcase
      locked_d = (state_d == RX_LOCKED);
   end

   // State, shift register and output registers.
   always_ff @(posedge bck176 or negedge reset_n) begin
      if (!reset_n) begin
         sr_q           <= {(WORD_W-1){1'b0}};
         state_q        <= RX_HUNT;
         good_cnt_q     <= 3'd0;
         x0_q           <= {WIDTH{1'b0}};
         x1_q           <= {WIDTH{1'b0}};
         frame_strobe_q <= 1'b0;
         slip_err_q     <= 1'b0;
         locked_q       <= 1'b0;
      end else begin
         sr_q           <= sr_d;
         state_q        <= state_d;
         good_cnt_q     <= good_cnt_d;
         x0_q           <= x0_d;
         x1_q           <= x1_d;
         frame_strobe_q <= frame_strobe_d;
         slip_err_q     <= slip_err_d;
         locked_q       <= locked_d;
      end
   end

   assign bus.x0           = x0_q;
   assign bus.x1           = x1_q;
   assign bus.frame_strobe = frame_strobe_q;
   assign bus.slip_err     = slip_err_q;
   assign bus.locked       = locked_q;

endmodule
